l2_norm_stream: RTL and testbench

- Parametrised streaming sum-of-squares engine. It is the next generation of the fixed 8-bit/20-bit part2 MAC.
- Consumes signed samples under a valid/ready handshake and computes f = Σ a² over every VEC_LEN accepted samples.
- Presents each result with a per-vector overflow flag under a valid/ready output handshake.
- Sits between the sample source and the norm/sqrt stage. Backpressure propagates through the whole pipeline.

---
 rtl/l2_norm_pkg.sv | 35 +++
 rtl/l2_sat_accum.sv | 68 ++++++
 rtl/l2_norm_stream.sv | 117 +++++++++++
 tb/tb_l2_norm_stream.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_norm_pkg.sv
// Shared definitions for the sum-of-squares datapath and the downstream norm stage.
//   L2_IN_W / L2_ACC_W / L2_VEC_LEN : default sample width, result width, vector length
//   sat_res_t                       : {ovf, sum} pair returned by sat_add
//   sat_add(acc, p, sticky, w)      : w-bit saturating add with sticky overflow
package l2_norm_pkg;

    localparam int unsigned L2_IN_W    = 8;
    localparam int unsigned L2_ACC_W   = 20;
    localparam int unsigned L2_VEC_LEN = 4;

    // Widest accumulator the helper supports; callers zero-extend into it.
    localparam int unsigned L2_MAX_W   = 64;

    typedef struct packed {
        logic                ovf;
        logic [L2_MAX_W-1:0] sum;
    } sat_res_t;

    // Adds p to acc at w+1 bits; a carry out of bit w-1, or an already set sticky
    // flag, pins the result to w ones and raises ovf.
    function automatic sat_res_t sat_add(input logic [L2_MAX_W-1:0] acc,
                                         input logic [L2_MAX_W-1:0] p,
                                         input logic                sticky,
                                         input int unsigned         w);
        sat_res_t          res;
        logic [L2_MAX_W:0] sum;
        logic [L2_MAX_W:0] lim;
        sum     = {1'b0, acc} + {1'b0, p};
        lim     = (L2_MAX_W+1)'(1) << w;
        res.ovf = sticky || (sum >= lim);
        res.sum = res.ovf ? L2_MAX_W'(lim - (L2_MAX_W+1)'(1)) : L2_MAX_W'(sum);
        return res;
    endfunction

endpackage

// File: rtl/l2_sat_accum.sv
// S3 of l2_norm_stream: saturating accumulator, element counter and result-load strobe.
//   clk, reset  : clock, async active-high reset
//   p, v2       : unsigned square and its valid from S2
//   hold        : downstream stall, freezes all state
//   clear       : synchronous abort of the partial vector
//   done_c      : a vector completes on this edge (load the output register)
//   res_c       : saturated running sum including p
//   res_ovf_c   : sticky overflow including p
module l2_sat_accum
    import l2_norm_pkg::*;
#(
    parameter int unsigned PW      = 16,
    parameter int unsigned ACC_W   = L2_ACC_W,
    parameter int unsigned VEC_LEN = L2_VEC_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PW-1:0]    p,
    input  logic             v2,
    input  logic             hold,
    input  logic             clear,
    output logic             done_c,
    output logic [ACC_W-1:0] res_c,
    output logic             res_ovf_c
);

    localparam int unsigned    CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    sat_res_t         r;
    logic             unused_hi;

    // Next accumulator value and completion strobe.
    always_comb begin
        r         = sat_add(L2_MAX_W'(acc), L2_MAX_W'(p), ovf, ACC_W);
        res_c     = r.sum[ACC_W-1:0];
        res_ovf_c = r.ovf;
        unused_hi = ^r.sum[L2_MAX_W-1:ACC_W];
        done_c    = v2 && !hold && !clear && (cnt == LAST);
    end

    // Accumulate each valid square; restart after the last element of a vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (v2 && !hold) begin
            if (cnt == LAST) begin
                acc <= '0;
                ovf <= 1'b0;
                cnt <= '0;
            end else begin
                acc <= res_c;
                ovf <= res_ovf_c;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/l2_norm_stream.sv
// Streaming sum of squares over VEC_LEN signed samples, saturated to ACC_W bits.
//   clk, reset           : clock, async active-high reset
//   a, valid_in, ready_in: sample input handshake (ready_in is combinational)
//   clear                : synchronous abort of the partial vector
//   f, overflow          : result and per-vector saturation flag
//   valid_out, ready_out : result output handshake
module l2_norm_stream
    import l2_norm_pkg::*;
#(
    parameter int unsigned IN_W    = L2_IN_W,
    parameter int unsigned ACC_W   = L2_ACC_W,
    parameter int unsigned VEC_LEN = L2_VEC_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             clear,
    output logic [ACC_W-1:0] f,
    output logic             overflow,
    output logic             valid_out,
    input  logic             ready_out
);

    localparam int unsigned PW = 2 * IN_W;

    if (ACC_W < PW) begin : g_bad_acc_w
        $error("l2_norm_stream: ACC_W must be at least 2*IN_W");
    end
    if (ACC_W >= L2_MAX_W) begin : g_bad_acc_max
        $error("l2_norm_stream: ACC_W exceeds sat_add width");
    end
    if (VEC_LEN < 1) begin : g_bad_len
        $error("l2_norm_stream: VEC_LEN must be at least 1");
    end

    logic                   stall;
    logic                   accept;
    logic signed [IN_W-1:0] a1;
    logic                   v1;
    logic signed [PW-1:0]   a1_ext;
    logic [PW-1:0]          sq;
    logic [PW-1:0]          p2;
    logic                   v2;
    logic                   done_c;
    logic [ACC_W-1:0]       res_c;
    logic                   res_ovf_c;

    assign stall    = valid_out && !ready_out;
    assign ready_in = !stall;
    assign accept   = valid_in && ready_in && !clear;

    // Sign-extend before squaring; the square of the most negative sample fits in PW bits.
    assign a1_ext = PW'(a1);
    assign sq     = a1_ext * a1_ext;

    // S1: sample capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a1 <= '0;
            v1 <= 1'b0;
        end else if (clear) begin
            v1 <= 1'b0;
        end else if (!stall) begin
            v1 <= accept;
            if (accept) begin
                a1 <= a;
            end
        end
    end

    // S2: registered square.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p2 <= '0;
            v2 <= 1'b0;
        end else if (clear) begin
            v2 <= 1'b0;
        end else if (!stall) begin
            p2 <= sq;
            v2 <= v1;
        end
    end

    l2_sat_accum #(
        .PW      (PW),
        .ACC_W   (ACC_W),
        .VEC_LEN (VEC_LEN)
    ) u_accum (
        .clk       (clk),
        .reset     (reset),
        .p         (p2),
        .v2        (v2),
        .hold      (stall),
        .clear     (clear),
        .done_c    (done_c),
        .res_c     (res_c),
        .res_ovf_c (res_ovf_c)
    );

    // Output register: a new result wins over a same-cycle transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f         <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else if (done_c) begin
            f         <= res_c;
            overflow  <= res_ovf_c;
            valid_out <= 1'b1;
        end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l2_norm_stream.sv
// Bench for l2_norm_stream: two instances (ACC_W=20 and ACC_W=16) share stimulus and
// are checked every cycle against a vector-level model, plus literal result checks.
module tb_l2_norm_stream;

    localparam int VL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  a = '0;
    logic        valid_in = 1'b0;
    logic        clear = 1'b0;
    logic        ready_out = 1'b1;

    logic        ready_in20, ovf20, vout20;
    logic [19:0] f20;
    logic        ready_in16, ovf16, vout16;
    logic [15:0] f16;

    int errors = 0;
    int checks = 0;

    l2_norm_stream #(.IN_W(8), .ACC_W(20), .VEC_LEN(VL)) dut20 (
        .clk(clk), .reset(reset), .a(a), .valid_in(valid_in), .ready_in(ready_in20),
        .clear(clear), .f(f20), .overflow(ovf20), .valid_out(vout20), .ready_out(ready_out));

    l2_norm_stream #(.IN_W(8), .ACC_W(16), .VEC_LEN(VL)) dut16 (
        .clk(clk), .reset(reset), .a(a), .valid_in(valid_in), .ready_in(ready_in16),
        .clear(clear), .f(f16), .overflow(ovf16), .valid_out(vout16), .ready_out(ready_out));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint satf(input longint s, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (s > m) ? m : s;
    endfunction

    function automatic longint sato(input longint s, input int w);
        return (s > ((longint'(1) << w) - 1)) ? 1 : 0;
    endfunction

    // Model: completed vector sums travel through a two-step latency queue, then
    // land in an output slot that holds until transferred.
    typedef struct { longint s; int age; } fl_t;
    typedef struct { longint f20; longint o20; longint f16; longint o16; } ob_t;

    fl_t    flight[$];
    ob_t    obs[$];
    longint cur_sum = 0;
    int     cur_n   = 0;
    bit     exp_v   = 0;
    longint exp_s   = 0;

    always @(negedge clk) begin
        bit     stall;
        bit     done;
        longint ds;
        int     sv;
        ob_t    o;
        if (reset) begin
            flight.delete();
            cur_sum = 0; cur_n = 0; exp_v = 0; exp_s = 0;
            chk("rst.valid_out20", vout20, 0);
            chk("rst.f20", f20, 0);
            chk("rst.ovf20", ovf20, 0);
            chk("rst.ready_in20", ready_in20, 1);
            chk("rst.valid_out16", vout16, 0);
            chk("rst.f16", f16, 0);
        end else begin
            stall = exp_v && !ready_out;
            chk("valid_out20", vout20, exp_v);
            chk("valid_out16", vout16, exp_v);
            chk("ready_in20", ready_in20, !stall);
            chk("ready_in16", ready_in16, !stall);
            if (exp_v) begin
                chk("f20", f20, satf(exp_s, 20));
                chk("ovf20", ovf20, sato(exp_s, 20));
                chk("f16", f16, satf(exp_s, 16));
                chk("ovf16", ovf16, sato(exp_s, 16));
            end
            if (vout20 && ready_out) begin
                o.f20 = f20; o.o20 = ovf20; o.f16 = f16; o.o16 = ovf16;
                obs.push_back(o);
            end
            if (clear) begin
                flight.delete();
                cur_sum = 0; cur_n = 0;
            end
            if (!stall) begin
                done = 0; ds = 0;
                foreach (flight[i]) flight[i].age++;
                if (flight.size() > 0 && flight[0].age >= 2) begin
                    done = 1;
                    ds = flight[0].s;
                    void'(flight.pop_front());
                end
                if (exp_v && ready_out) exp_v = 0;
                if (done) begin
                    exp_v = 1;
                    exp_s = ds;
                end
                if (valid_in && !clear) begin
                    sv = int'($signed(a));
                    cur_sum += longint'(sv) * longint'(sv);
                    cur_n++;
                    if (cur_n == VL) begin
                        flight.push_back('{s: cur_sum, age: 0});
                        cur_sum = 0; cur_n = 0;
                    end
                end
            end
        end
    end

    task automatic send(input int v);
        bit got;
        got = 0;
        a = 8'(v);
        valid_in = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready_in20) begin
                got = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        if (!got) chk("send.timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string nm, input longint e20, input longint eo20,
                              input longint e16, input longint eo16);
        ob_t o;
        int  k;
        k = 0;
        while (obs.size() == 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (obs.size() == 0) begin
            chk({nm, ".timeout"}, 0, 1);
        end else begin
            o = obs.pop_front();
            chk({nm, ".f20"}, o.f20, e20);
            chk({nm, ".ovf20"}, o.o20, eo20);
            chk({nm, ".f16"}, o.f16, e16);
            chk({nm, ".ovf16"}, o.o16, eo16);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // back-to-back vector
        send(1); send(2); send(3); send(4);
        expect_res("b2b", 30, 0, 30, 0);

        // signed extremes
        send(-128); send(-128); send(127); send(-1);
        expect_res("extremes", 48898, 0, 48898, 0);

        // gaps, result held across a clear
        ready_out = 1'b0;
        send(3); idle(1); send(5); idle(2); send(0); send(7);
        for (int k = 0; k < 20 && !vout20; k++) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("gaps.held_valid", vout20, 1);
        chk("gaps.held_f", f20, 83);
        @(posedge clk); #1 ready_out = 1'b1;
        expect_res("gaps", 83, 0, 83, 0);

        // saturation on the 16-bit instance, sticky cleared per vector
        repeat (4) send(-128);
        expect_res("sat", 65536, 0, 65535, 1);
        repeat (4) send(1);
        expect_res("after_sat", 4, 0, 4, 0);

        // clear coinciding with completion suppresses the result
        repeat (4) send(1);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        idle(6);
        chk("clr_done.none", obs.size(), 0);
        repeat (4) send(2);
        expect_res("after_clr_done", 16, 0, 16, 0);

        // clear mid-vector, with a sample presented alongside it
        send(9); send(9); idle(3);
        a = 8'd100; valid_in = 1'b1; clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0; valid_in = 1'b0;
        send(1); send(2); send(3); send(4);
        expect_res("clr_mid", 30, 0, 30, 0);

        // backpressure
        ready_out = 1'b0;
        fork
            begin
                repeat (4) send(2);
                repeat (4) send(3);
            end
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                chk("bp.ready_in", ready_in20, 0);
                chk("bp.valid_out", vout20, 1);
                chk("bp.f_held", f20, 16);
                @(posedge clk); #1 ready_out = 1'b1;
            end
        join
        expect_res("bp.first", 16, 0, 16, 0);
        expect_res("bp.second", 36, 0, 36, 0);

        // reset mid-vector
        send(5); send(5);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.valid_out", vout20, 0);
        chk("rstmid.ready_in", ready_in20, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) send(1);
        expect_res("rstmid", 4, 0, 4, 0);
        idle(4);
        obs.delete();

        // randomized traffic with backpressure and occasional clears
        for (int c = 0; c < 600; c++) begin
            valid_in  = ($urandom_range(9) < 7);
            a         = 8'($urandom);
            ready_out = ($urandom_range(9) < 6);
            clear     = ($urandom_range(39) == 0);
            @(posedge clk); #1;
        end
        valid_in = 1'b0; clear = 1'b0; ready_out = 1'b1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
